// File: rtl/umi_regif_arb_if.sv
// Bundle of signals around umi_regif_arb: NREQ requester-side UMI request/response
// channels plus the single downstream register-interface request/response channel.
// slave  : the arbiter's view (it accepts requests from the host side).
// master : the environment's view (requesters and the device).
interface umi_regif_arb_if #(
    parameter int NREQ = 2,
    parameter int AW   = 64,
    parameter int CW   = 32,
    parameter int DW   = 256
);
    // requester side
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*CW-1:0] req_cmd;
    logic [NREQ*AW-1:0] req_dstaddr;
    logic [NREQ*AW-1:0] req_srcaddr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [CW-1:0]      resp_cmd;
    logic [AW-1:0]      resp_dstaddr;
    logic [AW-1:0]      resp_srcaddr;
    logic [DW-1:0]      resp_data;
    logic [NREQ-1:0]    resp_ready;
    // device side
    logic               dev_req_valid;
    logic [CW-1:0]      dev_req_cmd;
    logic [AW-1:0]      dev_req_dstaddr;
    logic [AW-1:0]      dev_req_srcaddr;
    logic [DW-1:0]      dev_req_data;
    logic               dev_req_ready;
    logic               dev_resp_valid;
    logic [CW-1:0]      dev_resp_cmd;
    logic [AW-1:0]      dev_resp_dstaddr;
    logic [AW-1:0]      dev_resp_srcaddr;
    logic [DW-1:0]      dev_resp_data;
    logic               dev_resp_ready;

    modport slave (
        input  req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        output req_ready,
        output resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        input  resp_ready,
        output dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data,
        input  dev_req_ready,
        input  dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data,
        output dev_resp_ready
    );

    modport master (
        output req_valid, req_cmd, req_dstaddr, req_srcaddr, req_data,
        input  req_ready,
        input  resp_valid, resp_cmd, resp_dstaddr, resp_srcaddr, resp_data,
        output resp_ready,
        input  dev_req_valid, dev_req_cmd, dev_req_dstaddr, dev_req_srcaddr, dev_req_data,
        output dev_req_ready,
        output dev_resp_valid, dev_resp_cmd, dev_resp_dstaddr, dev_resp_srcaddr, dev_resp_data,
        input  dev_resp_ready
    );
endinterface

// File: rtl/umi_regif_arb.sv
// umi_regif_arb: round-robin arbiter letting NREQ UMI requesters share one
// register-interface endpoint, with at most one transaction outstanding.
// Optional macro UMI_REGIF_ARB_TIMEOUT_EN adds a WAIT-state response timeout
// (ports timeout_err / timeout_id); without it WAIT waits indefinitely.
module umi_regif_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 64,
    parameter int CW   = 32,
    parameter int DW   = 256,
    parameter int TOW  = 8
) (
    input  logic                      clk,
    input  logic                      nreset,
    umi_regif_arb_if.slave            bus,
    output logic [$clog2(NREQ)-1:0]   grant_id
`ifdef UMI_REGIF_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err,
    output logic [$clog2(NREQ)-1:0]   timeout_id
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam logic [4:0] UMI_REQ_READ  = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE = 5'h03;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic            sel_vld;
    logic            resp_hs;
    logic            resp_expected;
    // latched request, held stable while SEND waits for the device
    logic [CW-1:0]   cmd_p0;
    logic [AW-1:0]   dstaddr_p0;
    logic [AW-1:0]   srcaddr_p0;
    logic [DW-1:0]   data_p0;

`ifdef UMI_REGIF_ARB_TIMEOUT_EN
    // expiry is taken on the cycle the counter would reach all-ones,
    // so WAIT lasts 2**TOW-1 cycles without a response
    localparam logic [TOW-1:0] TO_LAST = ~TOW'(1);
    logic [TOW-1:0]  to_cnt;
`endif

    // Round-robin search starting at ptr and wrapping; first valid wins
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NREQ;
            if (!sel_vld && bus.req_valid[j]) begin
                sel_vld = 1'b1;
                sel     = IW'(j);
            end
        end
    end

    // Ready goes only to the selected requester, and only while IDLE
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && sel_vld)
            bus.req_ready[sel] = 1'b1;
    end

    // Response steering: only the granted requester sees the device response
    always_comb begin
        bus.resp_valid     = '0;
        bus.dev_resp_ready = 1'b0;
        if (state == WAIT) begin
            bus.resp_valid[grant_id] = bus.dev_resp_valid;
            bus.dev_resp_ready       = bus.resp_ready[grant_id];
        end
    end

    // Downstream request and upstream response fields
    always_comb begin
        bus.dev_req_valid   = (state == SEND);
        bus.dev_req_cmd     = cmd_p0;
        bus.dev_req_dstaddr = dstaddr_p0;
        bus.dev_req_srcaddr = srcaddr_p0;
        bus.dev_req_data    = data_p0;
        bus.resp_cmd        = bus.dev_resp_cmd;
        bus.resp_dstaddr    = bus.dev_resp_dstaddr;
        bus.resp_srcaddr    = bus.dev_resp_srcaddr;
        bus.resp_data       = bus.dev_resp_data;
        resp_hs             = (state == WAIT) && bus.dev_resp_valid && bus.resp_ready[grant_id];
        // only reads and non-posted writes return a response
        resp_expected       = (cmd_p0[4:0] == UMI_REQ_READ) || (cmd_p0[4:0] == UMI_REQ_WRITE);
    end

    // Arbitration FSM: grant and latch, send downstream, wait for the response
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            cmd_p0      <= '0;
            dstaddr_p0  <= '0;
            srcaddr_p0  <= '0;
            data_p0     <= '0;
`ifdef UMI_REGIF_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        cmd_p0     <= bus.req_cmd[int'(sel)*CW +: CW];
                        dstaddr_p0 <= bus.req_dstaddr[int'(sel)*AW +: AW];
                        srcaddr_p0 <= bus.req_srcaddr[int'(sel)*AW +: AW];
                        data_p0    <= bus.req_data[int'(sel)*DW +: DW];
                        grant_id   <= sel;
                        ptr        <= (sel == IW'(NREQ-1)) ? '0 : sel + 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (bus.dev_req_ready) begin
                        state <= resp_expected ? WAIT : IDLE;
`ifdef UMI_REGIF_ARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (resp_hs) begin
                        state <= IDLE;
`ifdef UMI_REGIF_ARB_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        timeout_id  <= grant_id;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/umi_regif_arb.md
Name: umi_regif_arb

Overview:
- Arbitration front-end that lets NREQ independent UMI requesters share a single UMI register-interface endpoint (the regif device port).
- Grants one requester at a time, round-robin, and allows at most one outstanding transaction.
- Latches the granted request, forwards it downstream, then routes the matching response back to the originating requester.
- Sits between host-side UMI crossbar ports and the register-interface block of a peripheral.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 64, address width.
- CW, 32, command width.
- DW, 256, data width.
- TOW, 8, timeout counter width; used only with the optional feature.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_cmd  in  NREQ*CW  requester commands, requester i at [i*CW+:CW].
- req_dstaddr  in  NREQ*AW  destination addresses.
- req_srcaddr  in  NREQ*AW  source addresses.
- req_data  in  NREQ*DW  write data.
- req_ready  out  NREQ  per-requester ready.
- resp_valid  out  NREQ  per-requester response valid.
- resp_cmd  out  CW  shared response command.
- resp_dstaddr  out  AW  shared response destination address.
- resp_srcaddr  out  AW  shared response source address.
- resp_data  out  DW  shared response data.
- resp_ready  in  NREQ  per-requester response ready.
- dev_req_valid / dev_req_cmd / dev_req_dstaddr / dev_req_srcaddr / dev_req_data  out  1/CW/AW/AW/DW  downstream request.
- dev_req_ready  in  1  downstream request ready.
- dev_resp_valid / dev_resp_cmd / dev_resp_dstaddr / dev_resp_srcaddr / dev_resp_data  in  1/CW/AW/AW/DW  downstream response.
- dev_resp_ready  out  1  downstream response ready.
- grant_id  out  clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Clock and reset: one clock, clk; reset nreset is asynchronous, active-low.
- Reset values:
  - FSM in IDLE.
  - All valids and readies low.
  - grant_id=0; round-robin pointer=0.
  - Request holding registers zero.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - Round-robin select among asserted req_valid, searching from pointer upward with wrap.
  - req_ready[sel] is asserted combinationally for the selected requester only; all other bits stay 0.
  - On the handshake, latch cmd/dstaddr/srcaddr/data and grant_id=sel, then go to SEND.
  - Pointer becomes sel+1 mod NREQ.
  - No valid asserted: stay in IDLE.
- SEND:
  - dev_req_valid=1 with the latched fields.
  - Fields are held stable until dev_req_ready.
  - On the handshake:
    - opcode (cmd[4:0]) UMI_REQ_READ or UMI_REQ_WRITE -> WAIT.
    - Any other opcode (posted, atomic, unsupported) expects no response -> IDLE.
  - First dev_req_valid appears exactly one cycle after the upstream handshake.
- WAIT:
  - dev_resp_ready = resp_ready[grant_id].
  - resp_valid[grant_id] = dev_resp_valid; all other resp_valid bits are 0.
  - resp_* fields pass through combinationally from dev_resp_*.
  - On the handshake -> IDLE.
  - Responses arriving in IDLE or SEND are not accepted (dev_resp_ready=0).
- Throughput: best case is one posted write every 2 cycles, or one read every 3 cycles plus device latency.
- Fairness: a requester that is continuously valid is granted at least once every NREQ transactions.
- Simultaneous events: multiple valids in the same cycle are resolved by the round-robin pointer only.
- A requester dropping valid before the grant is legal and causes no grant to it.
- Reset asserted mid-transaction:
  - Immediate return to IDLE.
  - Any in-flight transaction is discarded.
  - No response is delivered after reset releases.

Optional Feature:
- Macro: UMI_REGIF_ARB_TIMEOUT_EN.
- Defined:
  - A TOW-bit counter clears on entry to WAIT and increments each WAIT cycle without a response handshake.
  - At all-ones the FSM forces IDLE.
  - It also asserts output timeout_err: 1 bit, sticky, cleared only by reset.
  - timeout_id (clog2(NREQ) bits) captures grant_id at expiry.
  - No response is sent to the requester.
- Undefined:
  - Counter and ports are absent.
  - WAIT waits indefinitely.

Test Plan:
- Single read: requester 0 sends READ (opcode 5'h01) dst=0x1000_0010 -> dev_req_valid one cycle after req handshake; device returns data 0xAB -> resp_valid[0]=1, resp_data[63:0]=0xAB, resp_valid[1]=0; FSM back in IDLE.
- Round-robin: NREQ=2, both requesters hold valid with posted writes (opcode 5'h05) for 6 transactions -> grant order 0,1,0,1,0,1; no dev_resp_ready ever asserted.
- Backpressure: dev_req_ready held low 5 cycles in SEND -> dev_req_* stable all 5 cycles; req_ready all 0 throughout.
- Response stall: in WAIT, resp_ready[1]=0 for 4 cycles with dev_resp_valid=1 -> dev_resp_ready=0 for those cycles; accepted on the cycle resp_ready[1] rises.
- Reset mid-WAIT: assert nreset low during an outstanding read -> all outputs at reset values asynchronously; a late dev_resp_valid after release is not accepted.
- Timeout (macro defined, TOW=4): read with no device response -> after 15 WAIT cycles FSM in IDLE, timeout_err=1, timeout_id=granted index; next request proceeds normally.
